rope_shock_handler: RTL

Consumer side of the rope electro-status bus driven by the rope timing controller. It samples the per-rope electroStatus, accumulates player/rope pixel collisions over each VGA frame and debounces lethal contact. It then runs a stun/cooldown state machine and issues a one-cycle shock event to game logic. It also produces per-rope blink enables so the rope drawing block can render the warning and lethal states.

---
 rtl/rope_shock_handler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rope_shock_handler.sv
// rtl/rope_shock_handler.sv - rope electro-status consumer: hit latch, debounce, stun/cooldown FSM, blink enables
module rope_shock_handler #(
  parameter int ROPES           = 6,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int STUN_FRAMES     = 45,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int BLINK_FRAMES    = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [ROPES-1:0][1:0] electroStatus,
  input  logic [ROPES-1:0]      ropeHit,
  output logic                  shockPulse,
  output logic [2:0]            shockRope,
  output logic                  playerFrozen,
  output logic                  invulnerable,
  output logic [ROPES-1:0]      ropeBlink,
  output logic [3:0]            shockCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STUN     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [2:0] DB_LAST    = 3'(DEBOUNCE_FRAMES - 1);
  localparam logic [7:0] STUN_LD    = 8'(STUN_FRAMES);
  localparam logic [7:0] COOL_LD    = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t           state;
  logic [2:0]       dbCnt;
  logic [7:0]       timer;
  logic [ROPES-1:0] hitLatch;
  logic [ROPES-1:0] qualHit;
  logic [ROPES-1:0] evalHit;
  logic             lethal;
  logic [2:0]       firstIdx;
  logic [7:0]       blinkCnt;
  logic             blinkPhase;
  logic [ROPES-1:0] blinkNext;

  // A hit only counts when the player touches a rope that is lethal in that very cycle
  always_comb begin
    qualHit = '0;
    for (int i = 0; i < ROPES; i++) begin
      qualHit[i] = ropeHit[i] && (electroStatus[i] == 2'b10);
    end
  end

  // Frame verdict: latched hits plus hits arriving in the SOF cycle itself (they belong to the ending frame)
  always_comb begin
    evalHit  = hitLatch | qualHit;
    lethal   = |evalHit;
    firstIdx = '0;
    for (int i = ROPES - 1; i >= 0; i--) begin
      if (evalHit[i]) firstIdx = 3'(i);
    end
  end

  // Accumulate qualified hits over the frame; the SOF cycle consumes them and starts a fresh frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitLatch <= '0;
    end else if (startOfFrame) begin
      hitLatch <= '0;
    end else begin
      hitLatch <= hitLatch | qualHit;
    end
  end

  // Shock state machine: debounce in IDLE, timed STUN then COOLDOWN, all registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      dbCnt        <= '0;
      timer        <= '0;
      shockPulse   <= 1'b0;
      shockRope    <= '0;
      shockCount   <= '0;
      playerFrozen <= 1'b0;
      invulnerable <= 1'b0;
    end else begin
      shockPulse <= 1'b0;
      if (startOfFrame) begin
        case (state)
          IDLE: begin
            if (lethal) begin
              if (dbCnt == DB_LAST) begin
                shockPulse   <= 1'b1;
                shockRope    <= firstIdx;
                if (shockCount != 4'd15) shockCount <= shockCount + 4'd1;
                timer        <= STUN_LD;
                dbCnt        <= '0;
                state        <= STUN;
                playerFrozen <= 1'b1;
                invulnerable <= 1'b1;
              end else begin
                dbCnt <= dbCnt + 3'd1;
              end
            end else begin
              dbCnt <= '0;
            end
          end
          STUN: begin
            if (timer == 8'd1) begin
              timer        <= COOL_LD;
              state        <= COOLDOWN;
              playerFrozen <= 1'b0;
            end else begin
              timer <= timer - 8'd1;
            end
          end
          COOLDOWN: begin
            if (timer == 8'd1) begin
              timer        <= '0;
              dbCnt        <= '0;
              state        <= IDLE;
              invulnerable <= 1'b0;
            end else begin
              timer <= timer - 8'd1;
            end
          end
          default: begin
            state        <= IDLE;
            dbCnt        <= '0;
            timer        <= '0;
            playerFrozen <= 1'b0;
            invulnerable <= 1'b0;
          end
        endcase
      end
    end
  end

  // Free-running warning blink: phase flips once every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blinkCnt   <= BLINK_LAST;
      blinkPhase <= 1'b1;
    end else if (startOfFrame) begin
      if (blinkCnt == 8'd0) begin
        blinkCnt   <= BLINK_LAST;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt - 8'd1;
      end
    end
  end

  // Per-rope overlay enable: warning blinks, lethal is solid, idle/unused code is dark
  always_comb begin
    blinkNext = '0;
    for (int i = 0; i < ROPES; i++) begin
      case (electroStatus[i])
        2'b01:   blinkNext[i] = blinkPhase;
        2'b10:   blinkNext[i] = 1'b1;
        default: blinkNext[i] = 1'b0;
      endcase
    end
  end

  // Register the overlay enables so the drawing block sees a clean value every cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ropeBlink <= '0;
    end else begin
      ropeBlink <= blinkNext;
    end
  end

endmodule
